// File: rtl/mux_nx1_pipe.sv
// N-input operand-select mux with a registered output stage, valid/ready handshake,
// a 2-entry skid buffer (main + skid register) and a synchronous flush.
module mux_nx1_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sel_err,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] m_data;
  logic             m_err;
  logic             m_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_err;
  logic             s_valid;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic             accept;
  logic             send;

  // Out-of-range selects yield zero data with the error flag set.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (int'(in_sel) == k) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready;
  assign send     = m_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_err   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid) begin
      // in_ready is low here, so only draining the skid entry is possible
      if (send) begin
        m_data  <= s_data;
        m_err   <= s_err;
        s_valid <= 1'b0;
      end
    end else begin
      if (accept && (!m_valid || send)) begin
        m_data  <= sel_data;
        m_err   <= sel_err;
        m_valid <= 1'b1;
      end else if (accept) begin
        s_data  <= sel_data;
        s_err   <= sel_err;
        s_valid <= 1'b1;
      end else if (send) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign out_data    = m_data;
  assign out_sel_err = m_err;
  assign out_valid   = m_valid;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Scoreboard bench for mux_nx1_pipe: a reference FIFO of selected beats is pushed on
// accept and popped on send; a second N=3 instance exercises the out-of-range select.
module tb_mux_nx1_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [127:0] in_data = '0;
  logic [2:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_sel_err;
  logic         out_valid;
  logic         out_ready = 1'b0;

  logic [95:0]  b_in_data = '0;
  logic [1:0]   b_in_sel = '0;
  logic         b_in_valid = 1'b0;
  logic         b_in_ready;
  logic [31:0]  b_out_data;
  logic         b_out_sel_err;
  logic         b_out_valid;

  int n_chk = 0;
  int n_pass = 0;

  logic [32:0] sb_q[$];
  logic        stalled = 1'b0;
  logic [31:0] held = '0;

  mux_nx1_pipe #(.WIDTH(32), .N(4), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel_err(out_sel_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_nx1_pipe #(.WIDTH(32), .N(3), .SEL_W(2)) dut_n3 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_sel_err(b_out_sel_err), .out_valid(b_out_valid),
    .out_ready(1'b1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [32:0] exp_beat(input logic [127:0] d, input logic [2:0] s);
    if (s < 3'd4) return {1'b0, d[s*32 +: 32]};
    return {1'b1, 32'h0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling mid-cycle between active edges.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      stalled = 1'b0;
    end else begin
      check("out_valid_occ", out_valid, sb_q.size() > 0);
      check("in_ready_occ", in_ready, sb_q.size() < 2);
      if (stalled) check("hold", out_data, held);
      if (out_valid && out_ready && sb_q.size() > 0)
        check("beat", {out_sel_err, out_data}, sb_q.pop_front());
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(exp_beat(in_data, in_sel));
    end
  end

  initial begin
    // reset with beats offered on both instances
    in_valid = 1'b1; in_data = {4{32'h5A5A5A5A}};
    b_in_valid = 1'b1; b_in_sel = 2'd1; b_in_data = {3{32'h77777777}};
    step(); step();
    rst = 1'b0; in_valid = 1'b0; b_in_valid = 1'b0;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_err", out_sel_err, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_b_valid", b_out_valid, 1'b0);
    check("rst_b_data", b_out_data, 32'h0);

    // streaming, no bubbles
    in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 3'(i); in_valid = 1'b1;
      step();
      check("stream_valid", out_valid, 1'b1);
      check("stream_data", out_data, 32'h11111111 * (i + 1));
    end
    in_valid = 1'b0;
    step();
    check("stream_idle", out_valid, 1'b0);

    // backpressure into the skid register
    out_ready = 1'b0;
    in_data = {64'h0, 32'hCAFEF00D, 32'hDEADBEEF};
    in_sel = 3'd0; in_valid = 1'b1;
    step();
    in_sel = 3'd1;
    step();
    in_valid = 1'b0;
    check("skid_ready", in_ready, 1'b0);
    check("skid_hold_a", out_data, 32'hDEADBEEF);
    step();
    check("skid_hold_a2", out_data, 32'hDEADBEEF);
    out_ready = 1'b1;
    step();
    check("skid_b", out_data, 32'hCAFEF00D);
    check("skid_ready_back", in_ready, 1'b1);
    step();
    check("skid_drained", out_valid, 1'b0);

    // flush with both registers full and a beat offered
    out_ready = 1'b0;
    in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_sel = 3'd2; in_valid = 1'b1;
    step();
    in_sel = 3'd3;
    step();
    check("flush_pre_full", in_ready, 1'b0);
    in_sel = 3'd0; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    out_ready = 1'b1; in_sel = 3'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_flush_valid", out_valid, 1'b1);
    check("post_flush_data", out_data, 32'h22222222);
    step();
    check("post_flush_idle", out_valid, 1'b0);

    // out-of-range select on the N=3 instance
    b_in_data = {32'h33333333, 32'h22222222, 32'h11111111};
    b_in_sel = 2'd3; b_in_valid = 1'b1;
    step();
    check("oor_data", b_out_data, 32'h0);
    check("oor_err", b_out_sel_err, 1'b1);
    check("oor_valid", b_out_valid, 1'b1);
    b_in_sel = 2'd1;
    step();
    b_in_valid = 1'b0;
    check("oor_next_data", b_out_data, 32'h22222222);
    check("oor_next_err", b_out_sel_err, 1'b0);
    step();
    check("oor_idle", b_out_valid, 1'b0);

    // random traffic against the reference FIFO
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      flush     = ($urandom_range(0, 99) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    check("drain_empty", sb_q.size(), 0);
    check("drain_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
